// File: rtl/tlb_unit.sv
// Joint 32-entry TLB for the MEM stage.
// Holds the translation entries and executes TLBP/TLBR/TLBWI/TLBWR against the
// CP0 register values. It also translates the fetch and load/store addresses
// and owns the Random register.
// Read, probe and translate results are combinational. Writes land on the clock edge.
// There are no valid/ready handshakes. A TLB write is a single-cycle command
// (tlb_typeM) qualified by !stallM && !flushM. The change is visible from the next cycle.
module tlb_unit #(
  parameter int NUM_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  tlb_typeM,
  input  logic        stallM,
  input  logic        flushM,
  input  logic [31:0] cp0_entryHi,
  input  logic [31:0] cp0_pageMask,
  input  logic [31:0] cp0_entryLo0,
  input  logic [31:0] cp0_entryLo1,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_wired,
  output logic [31:0] tlb_entryHi,
  output logic [31:0] tlb_pageMask,
  output logic [31:0] tlb_entryLo0,
  output logic [31:0] tlb_entryLo1,
  output logic [31:0] tlb_index,
  output logic [4:0]  random_o,
  input  logic [31:0] inst_vaddr,
  output logic [31:0] inst_paddr,
  output logic        inst_miss,
  output logic        inst_invalid,
  input  logic [31:0] data_vaddr,
  input  logic        data_we,
  output logic [31:0] data_paddr,
  output logic        data_miss,
  output logic        data_invalid,
  output logic        data_modified
);

  localparam logic [2:0] OP_TLBWI = 3'b011;
  localparam logic [2:0] OP_TLBWR = 3'b100;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        modified;
  } xlate_t;

  // Entry storage, one array per field
  logic [18:0] vpn2_q [NUM_ENTRIES];
  logic [7:0]  asid_q [NUM_ENTRIES];
  logic [11:0] mask_q [NUM_ENTRIES];
  logic        g_q    [NUM_ENTRIES];
  logic [19:0] pfn0_q [NUM_ENTRIES];
  logic [2:0]  c0_q   [NUM_ENTRIES];
  logic        d0_q   [NUM_ENTRIES];
  logic        v0_q   [NUM_ENTRIES];
  logic [19:0] pfn1_q [NUM_ENTRIES];
  logic [2:0]  c1_q   [NUM_ENTRIES];
  logic        d1_q   [NUM_ENTRIES];
  logic        v1_q   [NUM_ENTRIES];

  logic [4:0]  random_q, random_d;
  logic [4:0]  wired_q;

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [5:0]  probe;
  xlate_t      inst_x, data_x;

  function automatic logic [3:0] popcnt12(input logic [11:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r = r + {3'b000, m[i]};
    return r;
  endfunction

  function automatic logic entry_match(input logic [4:0] e, input logic [18:0] vpn,
                                       input logic [7:0] asid);
    logic [18:0] m;
    m = {7'b0, mask_q[e]};
    return ((vpn2_q[e] & ~m) == (vpn & ~m)) && (g_q[e] || (asid_q[e] == asid));
  endfunction

  // Returns {hit, index}. The scan runs downward so the lowest matching index is kept.
  function automatic logic [5:0] lookup(input logic [18:0] vpn, input logic [7:0] asid);
    logic [5:0] r;
    r = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entry_match(5'(i), vpn, asid)) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

  function automatic xlate_t translate(input logic [31:0] va, input logic we);
    logic [5:0]  hit;
    logic [4:0]  e;
    logic [3:0]  k;
    logic [4:0]  sel;
    logic        odd;
    logic [31:0] offmask;
    logic [19:0] pfn;
    logic        v;
    logic        d;
    xlate_t      r;
    hit = lookup(va[31:13], cp0_entryHi[7:0]);
    e   = hit[4:0];
    k   = popcnt12(mask_q[e]);
    sel = 5'd12 + {1'b0, k};
    odd = va[sel];
    // A contiguous mask of k ones gives (0x1000<<k)-1. That is the mask itself above a 4 KB offset.
    offmask = {8'b0, mask_q[e], 12'hFFF};
    pfn = odd ? pfn1_q[e] : pfn0_q[e];
    v   = odd ? v1_q[e]   : v0_q[e];
    d   = odd ? d1_q[e]   : d0_q[e];
    if (va[31:30] == 2'b10) begin
      r.paddr    = va & 32'h1FFF_FFFF;
      r.miss     = 1'b0;
      r.invalid  = 1'b0;
      r.modified = 1'b0;
    end else begin
      r.paddr    = ({pfn, 12'b0} & ~offmask) | (va & offmask);
      r.miss     = ~hit[5];
      r.invalid  = hit[5] & ~v;
      r.modified = we & hit[5] & v & ~d;
    end
    return r;
  endfunction

  assign wr_en  = ~stallM & ~flushM & ((tlb_typeM == OP_TLBWI) | (tlb_typeM == OP_TLBWR));
  assign wr_idx = (tlb_typeM == OP_TLBWR) ? random_q : cp0_index[4:0];

  // Entry array: cleared on reset, one entry written per qualified TLBWI/TLBWR
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        mask_q[i] <= '0;
        g_q[i]    <= 1'b0;
        pfn0_q[i] <= '0;
        c0_q[i]   <= '0;
        d0_q[i]   <= 1'b0;
        v0_q[i]   <= 1'b0;
        pfn1_q[i] <= '0;
        c1_q[i]   <= '0;
        d1_q[i]   <= 1'b0;
        v1_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      vpn2_q[wr_idx] <= cp0_entryHi[31:13];
      asid_q[wr_idx] <= cp0_entryHi[7:0];
      mask_q[wr_idx] <= cp0_pageMask[24:13];
      g_q[wr_idx]    <= cp0_entryLo0[0] & cp0_entryLo1[0];
      pfn0_q[wr_idx] <= cp0_entryLo0[25:6];
      c0_q[wr_idx]   <= cp0_entryLo0[5:3];
      d0_q[wr_idx]   <= cp0_entryLo0[2];
      v0_q[wr_idx]   <= cp0_entryLo0[1];
      pfn1_q[wr_idx] <= cp0_entryLo1[25:6];
      c1_q[wr_idx]   <= cp0_entryLo1[5:3];
      d1_q[wr_idx]   <= cp0_entryLo1[2];
      v1_q[wr_idx]   <= cp0_entryLo1[1];
    end
  end

  // Random next value: restart at 31 on a Wired change or on reaching the wired floor
  always_comb begin
    random_d = random_q - 5'd1;
    if (cp0_wired[4:0] != wired_q) random_d = 5'd31;
    else if (random_q <= wired_q)  random_d = 5'd31;
  end

  // Random and Wired registers; stalls do not freeze them
  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= 5'd31;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= cp0_wired[4:0];
    end
  end

  assign random_o = random_q;

  // TLBR view of the entry selected by Index
  always_comb begin
    tlb_entryHi  = {vpn2_q[cp0_index[4:0]], 5'b0, asid_q[cp0_index[4:0]]};
    tlb_pageMask = {7'b0, mask_q[cp0_index[4:0]], 13'b0};
    tlb_entryLo0 = {6'b0, pfn0_q[cp0_index[4:0]], c0_q[cp0_index[4:0]],
                    d0_q[cp0_index[4:0]], v0_q[cp0_index[4:0]], g_q[cp0_index[4:0]]};
    tlb_entryLo1 = {6'b0, pfn1_q[cp0_index[4:0]], c1_q[cp0_index[4:0]],
                    d1_q[cp0_index[4:0]], v1_q[cp0_index[4:0]], g_q[cp0_index[4:0]]};
  end

  // TLBP: probe EntryHi against all entries
  always_comb begin
    probe     = lookup(cp0_entryHi[31:13], cp0_entryHi[7:0]);
    tlb_index = probe[5] ? {27'b0, probe[4:0]} : 32'h8000_0000;
  end

  // Concurrent fetch and load/store translation
  always_comb begin
    inst_x        = translate(inst_vaddr, 1'b0);
    data_x        = translate(data_vaddr, data_we);
    inst_paddr    = inst_x.paddr;
    inst_miss     = inst_x.miss;
    inst_invalid  = inst_x.invalid;
    data_paddr    = data_x.paddr;
    data_miss     = data_x.miss;
    data_invalid  = data_x.invalid;
    data_modified = data_x.modified;
  end

  // Register bits that carry no TLB state
  logic unused_bits;
  assign unused_bits = ^{cp0_index[31:5], cp0_wired[31:5], cp0_entryHi[12:8],
                         cp0_pageMask[31:25], cp0_pageMask[12:0],
                         cp0_entryLo0[31:26], cp0_entryLo1[31:26], inst_x.modified};

endmodule
